// File: rtl/boot_copy_ctrl.sv
// Boot sequencer: holds the core out of fetch, optionally copies a fixed-size image
// BOOTROM -> IMEM with single-beat AXI transfers, then releases the core.
package boot_copy_pkg;

  typedef struct packed {
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [3:0]  awregion;
    logic        awuser;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wuser;
    logic        wvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        aruser;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } s_axi_miso_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

endpackage

module boot_copy_ctrl
  import boot_copy_pkg::*;
#(
  parameter logic [31:0] SRC_ADDR   = 32'h0000_0000,
  parameter logic [31:0] DST_ADDR   = 32'hA000_0000,
  parameter int unsigned COPY_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_locked_i,
  input  logic        copy_en_i,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i,
  output logic        start_fetch_o,
  output logic [31:0] start_addr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] checksum_o
);

  localparam int CNT_W = $clog2(COPY_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RUN, ERR
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      buf_q;
  logic [31:0]      checksum_q;
  logic [31:0]      start_addr_q;
  logic             start_fetch_q, done_q, err_q, busy_q;
  logic             arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  logic [31:0]      byte_off;
  logic             aw_ok, w_ok, last_word;

  assign byte_off  = {{(30-CNT_W){1'b0}}, cnt_q, 2'b00};
  // A channel is finished once its valid has dropped or its handshake is happening now.
  assign aw_ok     = !awvalid_q || axi_miso_i.awready;
  assign w_ok      = !wvalid_q  || axi_miso_i.wready;
  assign last_word = (cnt_q + CNT_W'(1)) == CNT_W'(COPY_WORDS);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      buf_q         <= '0;
      checksum_q    <= '0;
      start_addr_q  <= SRC_ADDR;
      start_fetch_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clk_locked_i) begin
            if (copy_en_i) begin
              cnt_q      <= '0;
              checksum_q <= '0;
              arvalid_q  <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= RD_ADDR;
            end else begin
              start_addr_q  <= SRC_ADDR;
              start_fetch_q <= 1'b1;
              done_q        <= 1'b1;
              state_q       <= RUN;
            end
          end
        end
        RD_ADDR: begin
          if (axi_miso_i.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_miso_i.rvalid) begin
            rready_q <= 1'b0;
            if (axi_miso_i.rresp != AXI_RESP_OKAY) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ERR;
            end else begin
              buf_q     <= axi_miso_i.rdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (axi_miso_i.awready) awvalid_q <= 1'b0;
          if (axi_miso_i.wready)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_miso_i.bvalid) begin
            bready_q <= 1'b0;
            if (axi_miso_i.bresp != AXI_RESP_OKAY) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ERR;
            end else begin
              checksum_q <= checksum_q ^ buf_q;
              cnt_q      <= cnt_q + CNT_W'(1);
              if (last_word) begin
                start_addr_q  <= DST_ADDR;
                start_fetch_q <= 1'b1;
                done_q        <= 1'b1;
                busy_q        <= 1'b0;
                state_q       <= RUN;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= RD_ADDR;
              end
            end
          end
        end
        RUN, ERR: state_q <= state_q;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the blanket '0 default first means every field is assigned on every
  // pass, so no latch can be inferred and all unused AXI fields are tied off.
  always_comb begin
    axi_mosi_o         = '0;
    axi_mosi_o.araddr  = SRC_ADDR + byte_off;
    axi_mosi_o.arsize  = AXI_SIZE_WORD;
    axi_mosi_o.arburst = AXI_BURST_INCR;
    axi_mosi_o.arvalid = arvalid_q;
    axi_mosi_o.rready  = rready_q;
    axi_mosi_o.awaddr  = DST_ADDR + byte_off;
    axi_mosi_o.awsize  = AXI_SIZE_WORD;
    axi_mosi_o.awburst = AXI_BURST_INCR;
    axi_mosi_o.awvalid = awvalid_q;
    axi_mosi_o.wdata   = buf_q;
    axi_mosi_o.wstrb   = 4'hF;
    axi_mosi_o.wlast   = 1'b1;
    axi_mosi_o.wvalid  = wvalid_q;
    axi_mosi_o.bready  = bready_q;
  end

  assign start_fetch_o = start_fetch_q;
  assign start_addr_o  = start_addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign checksum_o    = checksum_q;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed + randomized bench for boot_copy_ctrl: an AXI slave with BOOTROM/IMEM
// arrays and configurable ready/valid latencies, checked against a word-level model.
module tb_boot_copy_ctrl;
  import boot_copy_pkg::*;

  localparam logic [31:0] SRC = 32'h0000_0000;
  localparam logic [31:0] DST = 32'hA000_0000;
  localparam int          N   = 4;

  logic        clk = 1'b0;
  logic        rst_n, lock, copy_en;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        start_fetch, busy, done, err;
  logic [31:0] start_addr, checksum;

  boot_copy_ctrl #(.SRC_ADDR(SRC), .DST_ADDR(DST), .COPY_WORDS(N)) dut (
    .clk(clk), .rst(rst_n), .clk_locked_i(lock), .copy_en_i(copy_en),
    .axi_mosi_o(mosi), .axi_miso_i(miso),
    .start_fetch_o(start_fetch), .start_addr_o(start_addr),
    .busy_o(busy), .done_o(done), .err_o(err), .checksum_o(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration (written by the stimulus) and bookkeeping (written by the slave).
  logic [31:0] rom  [N];
  logic [31:0] imem [N];
  int ar_d, r_d, aw_d, w_d, b_d, rd_err, wr_err;
  int ar_w, r_w, aw_w, w_w, b_w;
  logic rd_pend, b_pend, aw_got, w_got;
  logic [31:0] rd_addr, wr_addr, wr_data;
  int ar_cnt, aw_cnt, b_cnt, aw_hi, w_hi, any_valid, proto_bad;
  string proto_tag;
  logic [31:0] ar_q[$];
  s_axi_mosi_t prev;

  function automatic int widx(input logic [31:0] a, input logic [31:0] base);
    return int'((a - base) >> 2);
  endfunction

  function automatic int exp_cycles(input int a, input int r, input int aw, input int w, input int b);
    return 1 + N * (4 + a + r + ((aw > w) ? aw : w) + b);
  endfunction

  task automatic flag(input string tag);
    proto_bad++;
    proto_tag = tag;
  endtask

  // Everything is decided on the falling edge; handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      miso = '0; prev = '0;
      rd_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
      ar_cnt = 0; aw_cnt = 0; b_cnt = 0; aw_hi = 0; w_hi = 0; any_valid = 0;
      proto_bad = 0; proto_tag = "none";
      ar_q.delete();
      for (int i = 0; i < N; i++) imem[i] = '0;
    end else begin
      if (prev.arvalid && !miso.arready && !(mosi.arvalid && mosi.araddr == prev.araddr)) flag("ar_hold");
      if (prev.awvalid && !miso.awready && !(mosi.awvalid && mosi.awaddr == prev.awaddr)) flag("aw_hold");
      if (prev.wvalid && !miso.wready && !(mosi.wvalid && mosi.wdata == prev.wdata)) flag("w_hold");
      if (prev.arvalid && miso.arready && mosi.arvalid) flag("ar_nodrop");
      if (prev.awvalid && miso.awready && mosi.awvalid) flag("aw_nodrop");
      if (prev.wvalid && miso.wready && mosi.wvalid) flag("w_nodrop");
      if (mosi.arvalid && (mosi.awvalid || mosi.wvalid)) flag("rw_overlap");
      if ((mosi.arvalid || mosi.awvalid || mosi.wvalid || mosi.rready || mosi.bready) && !busy)
        flag("busy_low");
      if (mosi.arvalid && {mosi.arid, mosi.arlen, mosi.arsize, mosi.arburst, mosi.arlock,
          mosi.arcache, mosi.arprot, mosi.arqos, mosi.arregion, mosi.aruser} !==
          {8'd0, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}) flag("ar_fields");
      if (mosi.awvalid && {mosi.awid, mosi.awlen, mosi.awsize, mosi.awburst, mosi.awlock,
          mosi.awcache, mosi.awprot, mosi.awqos, mosi.awregion, mosi.awuser} !==
          {8'd0, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}) flag("aw_fields");
      if (mosi.wvalid && {mosi.wstrb, mosi.wlast, mosi.wuser} !== {4'hF, 1'b1, 1'b0}) flag("w_fields");
      if (mosi.arvalid || mosi.awvalid || mosi.wvalid) any_valid = 1;
      prev = mosi;

      miso.rvalid = 1'b0;
      if (rd_pend) begin
        if (r_w >= r_d) begin
          miso.rvalid = 1'b1;
          miso.rdata  = rom[widx(rd_addr, SRC)];
          miso.rresp  = (widx(rd_addr, SRC) == rd_err) ? 2'b10 : 2'b00;
          if (mosi.rready) rd_pend = 1'b0;
        end else r_w++;
      end

      miso.bvalid = 1'b0;
      if (b_pend) begin
        if (b_w >= b_d) begin
          miso.bvalid = 1'b1;
          miso.bresp  = (widx(wr_addr, DST) == wr_err) ? 2'b10 : 2'b00;
          if (mosi.bready) begin b_pend = 1'b0; b_cnt++; end
        end else b_w++;
      end

      miso.arready = 1'b0;
      if (mosi.arvalid) begin
        if (ar_w >= ar_d) begin
          miso.arready = 1'b1; ar_w = 0; ar_cnt++;
          ar_q.push_back(mosi.araddr);
          rd_addr = mosi.araddr; rd_pend = 1'b1; r_w = 0;
        end else ar_w++;
      end

      miso.awready = 1'b0;
      if (mosi.awvalid) begin
        aw_hi++;
        if (aw_w >= aw_d) begin
          miso.awready = 1'b1; aw_w = 0; aw_cnt++;
          wr_addr = mosi.awaddr; aw_got = 1'b1;
        end else aw_w++;
      end

      miso.wready = 1'b0;
      if (mosi.wvalid) begin
        w_hi++;
        if (w_w >= w_d) begin
          miso.wready = 1'b1; w_w = 0;
          wr_data = mosi.wdata; w_got = 1'b1;
        end else w_w++;
      end

      if (aw_got && w_got) begin
        imem[widx(wr_addr, DST)] = wr_data;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_w = 0;
      end
    end
  end

  task automatic set_slave(input int a, input int r, input int aw, input int w, input int b,
                           input int re, input int we);
    ar_d = a; r_d = r; aw_d = aw; w_d = w; b_d = b; rd_err = re; wr_err = we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lock = 1'b0; copy_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_end(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!start_fetch && !err && cyc < budget);
    check("ended_in_budget", 64'(start_fetch | err), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fetch"}, 64'(start_fetch), 64'd0);
    check({tag, "_addr"}, 64'(start_addr), 64'(SRC));
    check({tag, "_flags"}, 64'({busy, done, err}), 64'd0);
    check({tag, "_csum"}, 64'(checksum), 64'd0);
    check({tag, "_valids"},
          64'({mosi.arvalid, mosi.rready, mosi.awvalid, mosi.wvalid, mosi.bready}), 64'd0);
  endtask

  task automatic check_image(input string tag);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_imem%0d", tag, i), 64'(imem[i]), 64'(rom[i]));
      x = x ^ rom[i];
    end
    check({tag, "_csum"}, 64'(checksum), 64'(x));
    check({tag, "_addr"}, 64'(start_addr), 64'(DST));
    check({tag, "_fetch_done"}, 64'({start_fetch, done}), 64'b11);
    check({tag, "_busy_err"}, 64'({busy, err}), 64'd0);
    check({tag, "_bcount"}, 64'(b_cnt), 64'(N));
    check({tag, "_proto_", proto_tag}, 64'(proto_bad), 64'd0);
  endtask

  initial begin
    int cyc, k, hi;
    rst_n = 1'b0; lock = 1'b0; copy_en = 1'b0;
    miso = '0;
    set_slave(0, 0, 0, 0, 0, -1, -1);
    for (int i = 0; i < N; i++) rom[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Direct boot: lock rises after 9 idle cycles, fetch one cycle later at SRC.
    repeat (9) @(negedge clk);
    check("direct_waits_lock", 64'({start_fetch, busy}), 64'd0);
    lock = 1'b1;
    @(negedge clk);
    check("direct_fetch", 64'(start_fetch), 64'd1);
    check("direct_addr", 64'(start_addr), 64'(SRC));
    check("direct_done", 64'({done, busy, err}), 64'b100);
    copy_en = 1'b1;
    repeat (6) @(negedge clk);
    check("direct_no_axi", 64'(any_valid), 64'd0);
    check("direct_stays", 64'({start_fetch, start_addr}), 64'({1'b1, SRC}));

    // Four-word copy with zero-wait slave.
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h44; rom[3] = 32'h88;
    do_reset();
    lock = 1'b1; copy_en = 1'b1;
    run_until_end(200, cyc);
    check("copy4_latency", 64'(cyc), 64'(exp_cycles(0, 0, 0, 0, 0)));
    check("copy4_latency17", 64'(cyc), 64'd17);
    check("copy4_csum_ff", 64'(checksum), 64'hFF);
    check("copy4_ar_count", 64'(ar_cnt), 64'(N));
    check_image("copy4");

    // Skewed write handshake: awvalid held 3 cycles, wvalid 1 cycle per word.
    for (int i = 0; i < N; i++) rom[i] = $urandom();
    set_slave(0, 0, 2, 0, 0, -1, -1);
    do_reset();
    lock = 1'b1; copy_en = 1'b1;
    run_until_end(200, cyc);
    check("skew_latency", 64'(cyc), 64'(exp_cycles(0, 0, 2, 0, 0)));
    check("skew_aw_hold", 64'(aw_hi), 64'(3 * N));
    check("skew_w_hold", 64'(w_hi), 64'(N));
    check_image("skew");

    // Randomized data and channel latencies.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) rom[i] = $urandom();
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), -1, -1);
      do_reset();
      lock = 1'b1; copy_en = 1'b1;
      run_until_end(400, cyc);
      check($sformatf("rand%0d_latency", t), 64'(cyc), 64'(exp_cycles(ar_d, r_d, aw_d, w_d, b_d)));
      check_image($sformatf("rand%0d", t));
    end

    // Read error on word 2: terminal ERR, no write for word 2.
    for (int i = 0; i < N; i++) rom[i] = $urandom();
    set_slave(0, 0, 0, 0, 0, 2, -1);
    do_reset();
    lock = 1'b1; copy_en = 1'b1;
    run_until_end(200, cyc);
    check("rderr_flags", 64'({err, busy, done, start_fetch}), 64'b1000);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start_fetch) hi++;
    end
    check("rderr_never_fetch", 64'(hi), 64'd0);
    check("rderr_aw_count", 64'(aw_cnt), 64'd2);
    check("rderr_aw_cycles", 64'(aw_hi), 64'd2);
    check("rderr_ar_count", 64'(ar_cnt), 64'd3);
    check("rderr_valids", 64'({mosi.arvalid, mosi.rready, mosi.awvalid, mosi.wvalid, mosi.bready}), 64'd0);
    check("rderr_csum", 64'(checksum), 64'(rom[0] ^ rom[1]));

    // Write error on word 0: checksum never updated.
    set_slave(0, 0, 0, 0, 0, -1, 0);
    do_reset();
    lock = 1'b1; copy_en = 1'b1;
    run_until_end(200, cyc);
    check("wrerr_flags", 64'({err, busy, done, start_fetch}), 64'b1000);
    check("wrerr_csum", 64'(checksum), 64'd0);
    check("wrerr_counts", 64'({8'(ar_cnt), 8'(b_cnt)}), 64'h0101);

    // Reset mid-copy while awvalid is up for word 1, then a clean restart.
    for (int i = 0; i < N; i++) rom[i] = $urandom();
    set_slave(0, 0, 3, 1, 0, -1, -1);
    do_reset();
    lock = 1'b1; copy_en = 1'b1;
    k = 0;
    while (!(mosi.awvalid && mosi.awaddr == DST + 32'd4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("midrst_aw1_seen", 64'({mosi.awvalid, mosi.awaddr}), 64'({1'b1, DST + 32'd4}));
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    set_slave($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), -1, -1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_until_end(400, cyc);
    check("midrst_first_ar", 64'((ar_q.size() > 0) ? ar_q[0] : 32'hFFFF_FFFF), 64'(SRC));
    check("midrst_latency", 64'(cyc), 64'(exp_cycles(ar_d, r_d, aw_d, w_d, b_d)));
    check_image("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
